// File: rtl/tlb_miss_walker_pkg.sv
// Shared types for the TLB miss walker: CAM command codes,
// walker states and the PTE valid-bit position.
package tlb_miss_walker_pkg;

  typedef enum logic [1:0] {
    CAM_NOP = 2'b00,
    CAM_INS = 2'b01,
    CAM_DEL = 2'b10,
    CAM_RD  = 2'b11
  } cam_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RD_WAIT,
    S_WALK,
    S_PT_WAIT,
    S_FILL,
    S_FILL_WAIT,
    S_RESP
  } walk_state_e;

  // PTE layout: page in [aw-1:0], valid flag directly above it.
  function automatic int pte_vbit(input int aw);
    return aw;
  endfunction

endpackage

// File: rtl/tlb_miss_walker_timer.sv
// Page-table timeout down-counter. start_i loads the limit, ack_i clears it,
// expired_o flags the last allowed wait cycle.
module tlb_pt_timer #(
  parameter int T = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int TW = $clog2(T + 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= TW'(T);
    end else if (ack_i) begin
      cnt_q <= '0;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign expired_o = (cnt_q == TW'(1));

endmodule

// File: rtl/tlb_miss_walker.sv
// TLB miss walker: reads the translation CAM, walks the page table on a
// miss, installs the PTE, retries once and responds with paddr or fault.
module tlb_miss_walker
  import tlb_miss_walker_pkg::*;
#(
  parameter int AW         = 8,
  parameter int PT_TIMEOUT = 15,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AW-1:0]    req_vaddr,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [AW-1:0]    resp_paddr,
  output logic             resp_fault,
  output logic [1:0]       cam_cmd,
  output logic [AW-1:0]    cam_key,
  output logic [AW-1:0]    cam_datain,
  input  logic [AW-1:0]    cam_dataout,
  input  logic             cam_outvalid,
  input  logic             cam_pagefault,
  input  logic             cam_outrdy,
  output logic             pt_req,
  output logic [AW-1:0]    pt_addr,
  input  logic             pt_ack,
  input  logic [AW:0]      pt_data,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int VB = pte_vbit(AW);

  walk_state_e      state_q;
  cam_cmd_e         cam_cmd_q;
  logic [AW-1:0]    vaddr_q;
  logic [AW-1:0]    page_q;
  logic             retry_q;
  logic [AW-1:0]    cam_key_q;
  logic [AW-1:0]    cam_datain_q;
  logic             pt_req_q;
  logic [AW-1:0]    pt_addr_q;
  logic             resp_valid_q;
  logic [AW-1:0]    resp_paddr_q;
  logic             resp_fault_q;
  logic [CNT_W-1:0] miss_cnt_q;
  logic             pt_expired;

  tlb_pt_timer #(
    .T(PT_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .start_i  (state_q == S_WALK),
    .ack_i    (pt_ack && state_q == S_PT_WAIT),
    .expired_o(pt_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cam_cmd_q    <= CAM_NOP;
      vaddr_q      <= '0;
      page_q       <= '0;
      retry_q      <= 1'b0;
      cam_key_q    <= '0;
      cam_datain_q <= '0;
      pt_req_q     <= 1'b0;
      pt_addr_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_paddr_q <= '0;
      resp_fault_q <= 1'b0;
      miss_cnt_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            vaddr_q   <= req_vaddr;
            cam_key_q <= req_vaddr;
            state_q   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (cam_outrdy) begin
            cam_cmd_q <= CAM_RD;
            state_q   <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          // a hit wins over a simultaneous pagefault
          if (cam_outvalid) begin
            cam_cmd_q    <= CAM_NOP;
            resp_valid_q <= 1'b1;
            resp_paddr_q <= cam_dataout;
            resp_fault_q <= 1'b0;
            state_q      <= S_RESP;
          end else if (cam_pagefault) begin
            cam_cmd_q <= CAM_NOP;
            if (retry_q) begin
              resp_valid_q <= 1'b1;
              resp_paddr_q <= '0;
              resp_fault_q <= 1'b1;
              state_q      <= S_RESP;
            end else begin
              if (miss_cnt_q != '1)
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
              state_q <= S_WALK;
            end
          end
        end
        S_WALK: begin
          pt_req_q  <= 1'b1;
          pt_addr_q <= vaddr_q;
          state_q   <= S_PT_WAIT;
        end
        S_PT_WAIT: begin
          // an ack on the expiry cycle still counts
          if (pt_ack) begin
            pt_req_q <= 1'b0;
            page_q   <= pt_data[AW-1:0];
            if (pt_data[VB]) begin
              state_q <= S_FILL;
            end else begin
              resp_valid_q <= 1'b1;
              resp_paddr_q <= '0;
              resp_fault_q <= 1'b1;
              state_q      <= S_RESP;
            end
          end else if (pt_expired) begin
            pt_req_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_paddr_q <= '0;
            resp_fault_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_FILL: begin
          if (cam_outrdy) begin
            cam_cmd_q    <= CAM_INS;
            cam_key_q    <= vaddr_q;
            cam_datain_q <= page_q;
            state_q      <= S_FILL_WAIT;
          end
        end
        S_FILL_WAIT: begin
          // skip the INS cycle itself; outrdy is only trusted after it
          cam_cmd_q <= CAM_NOP;
          if (cam_cmd_q == CAM_NOP && cam_outrdy) begin
            retry_q <= 1'b1;
            state_q <= S_LOOKUP;
          end
        end
        S_RESP: begin
          retry_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_paddr = resp_paddr_q;
  assign resp_fault = resp_fault_q;
  assign cam_cmd    = cam_cmd_q;
  assign cam_key    = cam_key_q;
  assign cam_datain = cam_datain_q;
  assign pt_req     = pt_req_q;
  assign pt_addr    = pt_addr_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_tlb_miss_walker.sv
// Bench for tlb_miss_walker: behavioural CAM and page-table models,
// vector table, scoreboard, reset and counter-saturation sequences.
module tb_tlb_miss_walker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_vaddr = 8'h00;
  logic       req_ready;
  logic       resp_valid;
  logic [7:0] resp_paddr;
  logic       resp_fault;
  logic [1:0] cam_cmd;
  logic [7:0] cam_key;
  logic [7:0] cam_datain;
  logic [7:0] cam_dataout = 8'h00;
  logic       cam_outvalid = 1'b0;
  logic       cam_pagefault = 1'b0;
  logic       cam_outrdy = 1'b1;
  logic       pt_req;
  logic [7:0] pt_addr;
  logic       pt_ack = 1'b0;
  logic [8:0] pt_data = 9'h000;
  logic [15:0] miss_cnt;

  logic       rst_sat = 1'b0;
  logic       s_ready, s_rv, s_fault, s_ptreq;
  logic [7:0] s_paddr, s_key, s_din, s_ptaddr;
  logic [1:0] s_cmd;
  logic [2:0] s_miss;

  always #5 clk = ~clk;

  tlb_miss_walker dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_vaddr(req_vaddr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_fault(resp_fault),
    .cam_cmd(cam_cmd), .cam_key(cam_key), .cam_datain(cam_datain),
    .cam_dataout(cam_dataout), .cam_outvalid(cam_outvalid),
    .cam_pagefault(cam_pagefault), .cam_outrdy(cam_outrdy),
    .pt_req(pt_req), .pt_addr(pt_addr), .pt_ack(pt_ack), .pt_data(pt_data),
    .miss_cnt(miss_cnt)
  );

  // Always-missing CAM, silent page table: every request is a counted miss.
  tlb_miss_walker #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(rst_sat),
    .req_valid(1'b1), .req_vaddr(8'h5A), .req_ready(s_ready),
    .resp_valid(s_rv), .resp_paddr(s_paddr), .resp_fault(s_fault),
    .cam_cmd(s_cmd), .cam_key(s_key), .cam_datain(s_din),
    .cam_dataout(8'h00), .cam_outvalid(1'b0),
    .cam_pagefault(1'b1), .cam_outrdy(1'b1),
    .pt_req(s_ptreq), .pt_addr(s_ptaddr), .pt_ack(1'b0), .pt_data(9'h000),
    .miss_cnt(s_miss)
  );

  // ---------------- CAM model ----------------
  logic [7:0] cam_mem [256];
  logic       cam_vld [256];
  int         cam_busy = 0;
  logic       both_mode = 1'b0;

  initial for (int i = 0; i < 256; i++) begin
    cam_vld[i] = 1'b0;
    cam_mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    cam_outvalid  <= 1'b0;
    cam_pagefault <= 1'b0;
    if (cam_busy > 0) begin
      cam_busy <= cam_busy - 1;
      if (cam_busy == 1) cam_outrdy <= 1'b1;
    end else if (cam_cmd == 2'b11) begin
      if (cam_vld[cam_key]) begin
        cam_outvalid  <= 1'b1;
        cam_dataout   <= cam_mem[cam_key];
        cam_pagefault <= both_mode;
      end else begin
        cam_pagefault <= 1'b1;
      end
    end else if (cam_cmd == 2'b01) begin
      cam_mem[cam_key] <= cam_datain;
      cam_vld[cam_key] <= 1'b1;
      cam_busy   <= 2;
      cam_outrdy <= 1'b0;
    end
  end

  // ---------------- page-table model ----------------
  int         pt_delay = 0;
  logic [8:0] pt_pte = 9'h000;
  int         pt_ctr = 0;

  always @(posedge clk) begin
    pt_ack <= 1'b0;
    if (pt_req && !pt_ack) begin
      pt_ctr <= pt_ctr + 1;
      if (pt_delay >= 0 && pt_ctr == pt_delay) begin
        pt_ack  <= 1'b1;
        pt_data <= pt_pte;
      end
    end else begin
      pt_ctr <= 0;
    end
  end

  // ---------------- monitors and scoreboard ----------------
  typedef struct {
    logic [7:0] paddr;
    logic       fault;
  } exp_t;

  exp_t sb_q [$];
  int   nvec = 0;
  int   nerr = 0;
  int   resp_cnt = 0;
  int   ins_cnt = 0;
  int   ptcyc = 0;
  int   bad_seq = 0;
  logic [7:0] ins_key, ins_data, pt_addr_seen;
  logic       prev_rv = 1'b0;
  logic [1:0] prev_cmd = 2'b00;

  always @(negedge clk) begin
    if (resp_valid) begin
      exp_t e;
      resp_cnt++;
      nvec++;
      if (sb_q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_resp got paddr=%h fault=%b want none",
                 resp_paddr, resp_fault);
      end else begin
        e = sb_q.pop_front();
        if (resp_paddr !== e.paddr || resp_fault !== e.fault) begin
          nerr++;
          $display("FAIL resp got paddr=%h fault=%b want paddr=%h fault=%b",
                   resp_paddr, resp_fault, e.paddr, e.fault);
        end
      end
      nvec++;
      if (prev_rv) begin
        nerr++;
        $display("FAIL resp_one_cycle got 2+ cycles want 1");
      end
    end
    if (cam_cmd == 2'b01) begin
      ins_cnt++;
      ins_key  = cam_key;
      ins_data = cam_datain;
    end
    if (pt_req) begin
      ptcyc++;
      pt_addr_seen = pt_addr;
    end
    if ((prev_cmd == 2'b11 && cam_cmd == 2'b01) ||
        (prev_cmd == 2'b01 && cam_cmd == 2'b11))
      bad_seq++;
    prev_rv  = resp_valid;
    prev_cmd = cam_cmd;
  end

  int   s_resp = 0;
  logic [2:0] s_at9 = 3'd0;
  logic s_wrapped = 1'b0;
  logic [2:0] s_prev = 3'd0;

  always @(negedge clk) begin
    if (s_rv) begin
      s_resp++;
      if (s_resp == 9) s_at9 = s_miss;
    end
    if (rst_sat && s_miss < s_prev) s_wrapped = 1'b1;
    s_prev = s_miss;
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] vaddr;
    logic       both;
    logic       pte_v;
    logic [7:0] pte_page;
    int         delay;
    logic [7:0] exp_paddr;
    logic       exp_fault;
    int         miss;
    int         ins;
    int         ptcyc;
    int         lat;
  } vec_t;

  vec_t vt [10];
  int   exp_miss = 0;

  task automatic check(input string name, input int got, input int want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int r0;
    int lat;
    both_mode = v.both;
    pt_delay  = v.delay;
    pt_pte    = {v.pte_v, v.pte_page};
    ins_cnt   = 0;
    ptcyc     = 0;
    exp_miss  = exp_miss + v.miss;
    sb_q.push_back('{v.exp_paddr, v.exp_fault});
    req_vaddr = v.vaddr;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    r0  = resp_cnt;
    lat = 0;
    while (resp_cnt == r0 && lat < 200) begin
      @(negedge clk); #1;
      lat++;
    end
    check("resp_seen", resp_cnt - r0, 1);
    if (v.lat > 0) check("hit_latency", lat, v.lat);
    @(negedge clk); #1;
    check("ready_after", int'(req_ready), 1);
    check("miss_cnt", int'(miss_cnt), exp_miss);
    check("ins_count", ins_cnt, v.ins);
    check("pt_req_cycles", ptcyc, v.ptcyc);
    if (v.ins > 0) begin
      check("ins_key", int'(ins_key), int'(v.vaddr));
      check("ins_data", int'(ins_data), int'(v.pte_page));
    end
    if (v.ptcyc > 0) check("pt_addr", int'(pt_addr_seen), int'(v.vaddr));
    both_mode = 1'b0;
  endtask

  initial begin
    int n;
    int r0;
    // vaddr both pte_v page delay exp_pa fault miss ins ptcyc lat
    vt[0] = '{8'h12, 1'b0, 1'b0, 8'h00,  3, 8'h34, 1'b0, 0, 0,  0, 4};
    vt[1] = '{8'h40, 1'b0, 1'b1, 8'hA5,  3, 8'hA5, 1'b0, 1, 1,  5, 0};
    vt[2] = '{8'h40, 1'b0, 1'b0, 8'h00,  3, 8'hA5, 1'b0, 0, 0,  0, 4};
    vt[3] = '{8'h55, 1'b0, 1'b0, 8'h77,  1, 8'h00, 1'b1, 1, 0,  3, 0};
    vt[4] = '{8'h66, 1'b0, 1'b1, 8'h99, -1, 8'h00, 1'b1, 1, 0, 15, 0};
    vt[5] = '{8'h67, 1'b0, 1'b1, 8'h3C, 13, 8'h3C, 1'b0, 1, 1, 15, 0};
    vt[6] = '{8'h55, 1'b0, 1'b1, 8'h11,  0, 8'h11, 1'b0, 1, 1,  2, 0};
    vt[7] = '{8'h67, 1'b0, 1'b0, 8'h00,  0, 8'h3C, 1'b0, 0, 0,  0, 4};
    vt[8] = '{8'h00, 1'b0, 1'b1, 8'hFF,  0, 8'hFF, 1'b0, 1, 1,  2, 0};
    vt[9] = '{8'h12, 1'b1, 1'b1, 8'h01,  0, 8'h34, 1'b0, 0, 0,  0, 4};

    cam_mem[8'h12] = 8'h34;
    cam_vld[8'h12] = 1'b1;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    rst_sat = 1'b1;
    @(negedge clk); #1;
    check("rst_ready", int'(req_ready), 1);
    check("rst_cam_cmd", int'(cam_cmd), 0);
    check("rst_pt_req", int'(pt_req), 0);
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_miss_cnt", int'(miss_cnt), 0);

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // reset while the walker is waiting on the page table
    pt_delay  = -1;
    ptcyc     = 0;
    req_vaddr = 8'h70;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!pt_req && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("midwalk_pt_req_seen", int'(pt_req), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midwalk_rst_pt_req", int'(pt_req), 0);
    check("midwalk_rst_cam_cmd", int'(cam_cmd), 0);
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check("midwalk_ready", int'(req_ready), 1);
    check("midwalk_miss_cnt", int'(miss_cnt), 0);
    r0 = resp_cnt;
    repeat (25) @(negedge clk);
    #1;
    check("midwalk_no_resp", resp_cnt - r0, 0);
    exp_miss = 0;

    run_vec(vt[2]);

    n = 0;
    while (s_resp < 9 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check("sat_resp_count_ge9", int'(s_resp >= 9), 1);
    check("sat_miss_cnt", int'(s_at9), 7);
    check("sat_no_wrap", int'(s_wrapped), 0);
    check("rd_ins_adjacent", bad_seq, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
